// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: load-use bubbles, branch redirect with refill
// bubbles, cache-stall freeze, and saturating event counters.
module pipe_hazard_ctrl #(
   parameter int REDIRECT_BUBBLES = 1,
   parameter int CNT_W            = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mem_ren,
   input  logic             ex_redirect,
   input  logic             icache_stall,
   input  logic             dcache_stall,
   input  logic             cnt_clr,
   output logic             stall_if,
   output logic             stall_id,
   output logic             stall_back,
   output logic             flush_if,
   output logic             flush_id,
   output logic             pc_redirect,
   output logic             refill_busy,
   output logic [CNT_W-1:0] cnt_load_use,
   output logic [CNT_W-1:0] cnt_redirect,
   output logic [CNT_W-1:0] cnt_stall
);

   localparam logic [0:0] RUN    = 1'b0;
   localparam logic [0:0] REFILL = 1'b1;

   logic [0:0]       r_state;
   logic [0:0]       r_state_next;
   logic [3:0]       r_bcnt;
   logic [3:0]       r_bcnt_next;
   logic             w_cstall;
   logic             w_lu_hz;
   logic             w_lu_bubble;
   logic [2:0]       w_inc;
   logic [CNT_W-1:0] r_cnt [3];

   assign w_cstall = icache_stall | dcache_stall;
   assign w_lu_hz  = ex_mem_ren & (ex_rd != 5'd0) &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

   always_comb begin
      stall_if     = 1'b0;
      stall_id     = 1'b0;
      stall_back   = 1'b0;
      flush_if     = 1'b0;
      flush_id     = 1'b0;
      pc_redirect  = 1'b0;
      w_lu_bubble  = 1'b0;
      r_state_next = r_state;
      r_bcnt_next  = r_bcnt;
      if (w_cstall) begin
         // Whole pipe frozen; a pending redirect or hazard stays visible in EX.
         stall_if   = 1'b1;
         stall_id   = 1'b1;
         stall_back = 1'b1;
      end else if (ex_redirect) begin
         pc_redirect = 1'b1;
         flush_if    = 1'b1;
         flush_id    = 1'b1;
         if (REDIRECT_BUBBLES > 0) begin
            r_state_next = REFILL;
            r_bcnt_next  = 4'(REDIRECT_BUBBLES);
         end else begin
            r_state_next = RUN;
            r_bcnt_next  = 4'd0;
         end
      end else if (r_state == REFILL) begin
         // ID holds a wrong-path instruction, so any hazard it shows is ignored.
         flush_if = 1'b1;
         flush_id = 1'b1;
         if (r_bcnt <= 4'd1) begin
            r_state_next = RUN;
            r_bcnt_next  = 4'd0;
         end else begin
            r_bcnt_next = r_bcnt - 4'd1;
         end
      end else if (w_lu_hz) begin
         stall_if    = 1'b1;
         flush_id    = 1'b1;
         w_lu_bubble = 1'b1;
      end
   end

   assign refill_busy = (r_state == REFILL);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= RUN;
         r_bcnt  <= 4'd0;
      end else begin
         r_state <= r_state_next;
         r_bcnt  <= r_bcnt_next;
      end
   end

   assign w_inc = {w_cstall, pc_redirect, w_lu_bubble};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
         always_ff @(posedge clk) begin
            if (rst || cnt_clr) begin
               r_cnt[gi] <= '0;
            end else if (w_inc[gi] && (r_cnt[gi] != {CNT_W{1'b1}})) begin
               r_cnt[gi] <= r_cnt[gi] + 1'b1;
            end
         end
      end
   endgenerate

   assign cnt_load_use = r_cnt[0];
   assign cnt_redirect = r_cnt[1];
   assign cnt_stall    = r_cnt[2];

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (REDIRECT_BUBBLES=2, CNT_W=4).
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
   logic       id_use_rs1 = 0, id_use_rs2 = 0, ex_mem_ren = 0, ex_redirect = 0;
   logic       icache_stall = 0, dcache_stall = 0, cnt_clr = 0;
   logic       stall_if, stall_id, stall_back, flush_if, flush_id, pc_redirect, refill_busy;
   logic [3:0] cnt_load_use, cnt_redirect, cnt_stall;
   logic [6:0] ctl;
   logic [6:0] exp_ctl;
   int         vectors = 0;
   int         miscompares = 0;

   // Order: stall_if stall_id stall_back flush_if flush_id pc_redirect refill_busy
   localparam logic [6:0] C_IDLE   = 7'b0000000;
   localparam logic [6:0] C_LU     = 7'b1000100;
   localparam logic [6:0] C_REDIR  = 7'b0001110;
   localparam logic [6:0] C_REFILL = 7'b0001101;
   localparam logic [6:0] C_FREEZE = 7'b1110000;
   localparam logic [6:0] C_FRZ_RF = 7'b1110001;

   assign ctl = {stall_if, stall_id, stall_back, flush_if, flush_id, pc_redirect, refill_busy};

   pipe_hazard_ctrl #(.REDIRECT_BUBBLES(2), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rd(ex_rd), .ex_mem_ren(ex_mem_ren), .ex_redirect(ex_redirect),
      .icache_stall(icache_stall), .dcache_stall(dcache_stall), .cnt_clr(cnt_clr),
      .stall_if(stall_if), .stall_id(stall_id), .stall_back(stall_back),
      .flush_if(flush_if), .flush_id(flush_id), .pc_redirect(pc_redirect),
      .refill_busy(refill_busy), .cnt_load_use(cnt_load_use),
      .cnt_redirect(cnt_redirect), .cnt_stall(cnt_stall)
   );

   always #5 clk = ~clk;

   task automatic idle();
      id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; ex_rd = 0; ex_mem_ren = 0;
      ex_redirect = 0; icache_stall = 0; dcache_stall = 0; cnt_clr = 0;
   endtask

   // Advance to the next falling edge with idle inputs.
   task automatic step();
      @(negedge clk);
      idle();
   endtask

   task automatic clear_counters();
      @(negedge clk); idle(); cnt_clr = 1;
      @(negedge clk); cnt_clr = 0;
   endtask

   task automatic test_reset();
      idle(); rst = 1;
      @(negedge clk); @(negedge clk); #1;
      vectors++;
      if (ctl !== C_IDLE) begin miscompares++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_IDLE); end
      vectors++;
      if ({cnt_load_use, cnt_redirect, cnt_stall} !== 12'h000) begin
         miscompares++;
         $display("FAIL reset_cnt got=%h/%h/%h exp=0/0/0", cnt_load_use, cnt_redirect, cnt_stall);
      end
      rst = 0;
   endtask

   task automatic test_load_use();
      clear_counters();
      ex_mem_ren = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1; #1;
      vectors++;
      if (ctl !== C_LU) begin miscompares++; $display("FAIL lu_rs1 got=%b exp=%b", ctl, C_LU); end
      step(); #1;
      vectors++;
      if (ctl !== C_IDLE) begin miscompares++; $display("FAIL lu_after got=%b exp=%b", ctl, C_IDLE); end
      vectors++;
      if (cnt_load_use !== 4'd1) begin miscompares++; $display("FAIL lu_cnt1 got=%0d exp=1", cnt_load_use); end
      ex_mem_ren = 1; ex_rd = 9; id_rs2 = 9; id_use_rs2 = 1; id_rs1 = 9; #1;
      vectors++;
      if (ctl !== C_LU) begin miscompares++; $display("FAIL lu_rs2 got=%b exp=%b", ctl, C_LU); end
      step();
      ex_mem_ren = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1; #1;
      vectors++;
      if (ctl !== C_IDLE) begin miscompares++; $display("FAIL lu_x0 got=%b exp=%b", ctl, C_IDLE); end
      step();
      ex_mem_ren = 1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 0; id_rs2 = 7; id_use_rs2 = 0; #1;
      vectors++;
      if (ctl !== C_IDLE) begin miscompares++; $display("FAIL lu_unused got=%b exp=%b", ctl, C_IDLE); end
      step();
      ex_mem_ren = 0; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 1; #1;
      vectors++;
      if (ctl !== C_IDLE) begin miscompares++; $display("FAIL lu_noload got=%b exp=%b", ctl, C_IDLE); end
      step(); #1;
      vectors++;
      if (cnt_load_use !== 4'd2) begin miscompares++; $display("FAIL lu_cnt2 got=%0d exp=2", cnt_load_use); end
   endtask

   task automatic test_redirect();
      clear_counters();
      ex_redirect = 1; #1;
      vectors++;
      if (ctl !== C_REDIR) begin miscompares++; $display("FAIL redir_c0 got=%b exp=%b", ctl, C_REDIR); end
      for (int i = 1; i <= 2; i++) begin
         step(); #1;
         vectors++;
         if (ctl !== C_REFILL) begin miscompares++; $display("FAIL redir_c%0d got=%b exp=%b", i, ctl, C_REFILL); end
      end
      step(); #1;
      vectors++;
      if (ctl !== C_IDLE) begin miscompares++; $display("FAIL redir_c3 got=%b exp=%b", ctl, C_IDLE); end
      vectors++;
      if (cnt_redirect !== 4'd1) begin miscompares++; $display("FAIL redir_cnt got=%0d exp=1", cnt_redirect); end
   endtask

   task automatic test_stall_redirect();
      clear_counters();
      for (int i = 0; i < 3; i++) begin
         ex_redirect = 1; dcache_stall = 1; #1;
         vectors++;
         if (ctl !== C_FREEZE) begin miscompares++; $display("FAIL hold_c%0d got=%b exp=%b", i, ctl, C_FREEZE); end
         @(negedge clk);
      end
      dcache_stall = 0; ex_redirect = 1; #1;
      vectors++;
      if (ctl !== C_REDIR) begin miscompares++; $display("FAIL hold_fire got=%b exp=%b", ctl, C_REDIR); end
      step(); #1;
      vectors++;
      if (cnt_stall !== 4'd3) begin miscompares++; $display("FAIL hold_cstall got=%0d exp=3", cnt_stall); end
      vectors++;
      if (cnt_redirect !== 4'd1) begin miscompares++; $display("FAIL hold_credir got=%0d exp=1", cnt_redirect); end
      step(); step();
   endtask

   task automatic test_stall_in_refill();
      clear_counters();
      ex_redirect = 1;
      step();
      ex_mem_ren = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1; #1;
      vectors++;
      if (ctl !== C_REFILL) begin miscompares++; $display("FAIL rf_lu_ignored got=%b exp=%b", ctl, C_REFILL); end
      for (int i = 0; i < 2; i++) begin
         step(); icache_stall = 1; #1;
         vectors++;
         if (ctl !== C_FRZ_RF) begin miscompares++; $display("FAIL rf_frz%0d got=%b exp=%b", i, ctl, C_FRZ_RF); end
      end
      step(); #1;
      vectors++;
      if (ctl !== C_REFILL) begin miscompares++; $display("FAIL rf_last got=%b exp=%b", ctl, C_REFILL); end
      step(); #1;
      vectors++;
      if (ctl !== C_IDLE) begin miscompares++; $display("FAIL rf_run got=%b exp=%b", ctl, C_IDLE); end
      vectors++;
      if (cnt_load_use !== 4'd0) begin miscompares++; $display("FAIL rf_lucnt got=%0d exp=0", cnt_load_use); end
   endtask

   task automatic test_redirect_vs_lu();
      clear_counters();
      ex_redirect = 1; ex_mem_ren = 1; ex_rd = 12; id_rs2 = 12; id_use_rs2 = 1; #1;
      vectors++;
      if (ctl !== C_REDIR) begin miscompares++; $display("FAIL rvl_ctl got=%b exp=%b", ctl, C_REDIR); end
      step(); step(); step(); #1;
      vectors++;
      if (cnt_load_use !== 4'd0) begin miscompares++; $display("FAIL rvl_lucnt got=%0d exp=0", cnt_load_use); end
      vectors++;
      if (cnt_redirect !== 4'd1) begin miscompares++; $display("FAIL rvl_rdcnt got=%0d exp=1", cnt_redirect); end
   endtask

   task automatic test_saturation();
      clear_counters();
      for (int i = 0; i < 20; i++) begin
         icache_stall = 1;
         @(negedge clk);
      end
      idle(); #1;
      vectors++;
      if (cnt_stall !== 4'd15) begin miscompares++; $display("FAIL sat_cstall got=%0d exp=15", cnt_stall); end
      icache_stall = 1; cnt_clr = 1;
      step(); #1;
      vectors++;
      if (cnt_stall !== 4'd0) begin miscompares++; $display("FAIL sat_clr got=%0d exp=0", cnt_stall); end
   endtask

   task automatic test_reset_in_refill();
      step();
      ex_redirect = 1;
      step(); #1;
      vectors++;
      if (ctl !== C_REFILL) begin miscompares++; $display("FAIL rst_pre got=%b exp=%b", ctl, C_REFILL); end
      rst = 1;
      step(); rst = 0; #1;
      vectors++;
      if (ctl !== C_IDLE) begin miscompares++; $display("FAIL rst_refill got=%b exp=%b", ctl, C_IDLE); end
      vectors++;
      if (cnt_redirect !== 4'd0) begin miscompares++; $display("FAIL rst_cnt got=%0d exp=0", cnt_redirect); end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_redirect();
      test_stall_redirect();
      test_stall_in_refill();
      test_redirect_vs_lu();
      test_saturation();
      test_reset_in_refill();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage RISC-V pipeline. It detects load-use hazards between the ID and EX stages, sequences the redirect after a taken branch or jump resolved in EX (including extra refill bubbles to cover fetch latency), and freezes the pipeline on cache stalls. It drives the stall/flush inputs of the IF, ID and back-end pipeline registers, and keeps saturating performance counters.

Parameters:
REDIRECT_BUBBLES, 1, extra cycles after the redirect cycle during which IF/ID and ID/EX are flushed (0..15)
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
id_rs1  in  5  rs1 index of the instruction in ID (decoder output)
id_rs2  in  5  rs2 index of the instruction in ID
id_use_rs1  in  1  instruction in ID reads rs1
id_use_rs2  in  1  instruction in ID reads rs2
ex_rd  in  5  rd of the instruction in EX (ID/EX register output)
ex_mem_ren  in  1  instruction in EX is a load
ex_redirect  in  1  EX resolved a taken branch, jal or jalr this cycle
icache_stall  in  1  instruction cache not ready
dcache_stall  in  1  data cache not ready
cnt_clr  in  1  synchronous clear of all counters
stall_if  out  1  hold PC and the IF/ID register
stall_id  out  1  hold the ID/EX register (ID-stage stall input)
stall_back  out  1  hold the EX/MEM and MEM/WB registers
flush_if  out  1  load a bubble into IF/ID
flush_id  out  1  load a bubble into ID/EX (ID-stage flush input)
pc_redirect  out  1  one-cycle pulse: PC loads the EX target
refill_busy  out  1  FSM is in REFILL
cnt_load_use  out  CNT_W  load-use bubbles inserted
cnt_redirect  out  CNT_W  redirects taken
cnt_stall  out  CNT_W  cycles frozen by a cache stall

Behaviour:
- Internal signals:
  - cstall = icache_stall | dcache_stall.
  - lu_hz = ex_mem_ren & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
- FSM states: RUN, REFILL. 4-bit down-counter bcnt.
- All outputs are combinational from the state, bcnt and the inputs. Outputs carry no register latency.
- Priority in every state, highest first:
  1. cstall: stall_if = stall_id = stall_back = 1. All flushes, pc_redirect and load-use handling are 0. State and bcnt hold. ex_redirect and lu_hz are deferred; they remain asserted because EX is frozen.
  2. ex_redirect: pc_redirect = flush_if = flush_id = 1, all stalls 0. If REDIRECT_BUBBLES > 0, go to REFILL with bcnt = REDIRECT_BUBBLES; otherwise stay in or return to RUN. This applies in REFILL too: a new redirect restarts the count.
  3. In REFILL: flush_if = flush_id = 1, stalls 0, lu_hz ignored (the ID instruction is wrong-path). bcnt decrements; at bcnt == 1 return to RUN.
  4. In RUN with lu_hz: stall_if = 1, flush_id = 1, stall_id = 0, flush_if = 0. Exactly one bubble is inserted, and the load advances.
  5. Otherwise all controls are 0.
- Invariants:
  - stall_id and flush_id are never both 1.
  - flush_if = 1 implies stall_if = 0.
  - pc_redirect = 1 only when cstall = 0.
- Counters: each saturates at all-ones. cnt_clr has priority over increment.
  - cnt_load_use increments on each case-4 cycle.
  - cnt_redirect increments on each pc_redirect.
  - cnt_stall increments on each cstall cycle.
- Reset: state = RUN, bcnt = 0, counters = 0. Combinational outputs are then 0 given idle inputs. Reset mid-REFILL returns to RUN on the next edge, and flushing stops.
- A rd/rs index of x0 never causes a hazard.

Test Plan:
1. Load-use: ex_mem_ren=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle of stall_if=1, flush_id=1, stall_id=0; cnt_load_use=1. With ex_rd=0 -> no hazard.
2. Redirect with REDIRECT_BUBBLES=2: ex_redirect pulse -> cycle 0 pc_redirect=1, flush_if=flush_id=1; cycles 1-2 flush_if=flush_id=1, refill_busy=1; cycle 3 all 0; cnt_redirect=1.
3. Redirect held during dcache_stall for 3 cycles -> stall_if=stall_id=stall_back=1, pc_redirect=0 for 3 cycles; redirect fires on the 4th cycle; cnt_stall=3.
4. icache_stall mid-REFILL (bcnt=1) for 2 cycles -> flushes drop and stalls assert; bcnt holds; one REFILL cycle follows, then RUN.
5. Redirect and lu_hz in the same cycle -> redirect wins; no load-use bubble counted.
6. Counter saturation with CNT_W=4: 20 stall cycles -> cnt_stall=15. cnt_clr together with an increment -> 0. rst asserted in REFILL -> RUN and all outputs 0 on the next cycle.
